// File: rtl/serial_add_ctrl_if.sv
// Handshake/bus bundle for serial_add_ctrl.
//   master (requester side): drives start, abort, a, b, cin;
//                            observes ready, busy, done, sum, cout
//   slave  (controller side): the reverse
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, abort, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, abort, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two half adders + OR)
// is reused LSB-first across a WIDTH-bit add, one bit per clock.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      serial_add_ctrl_if.slave: start/abort/a/b/cin in,
//            ready/busy/done/sum/cout out (all registered)
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  serial_add_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_carry;
  logic              r_cout;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic              w_clear;

  // Shared adder cell: two half adders, carries merged with an OR.
  logic w_ha1_s, w_ha1_c, w_ha2_c, w_s, w_co;
  assign w_ha1_s = r_a[0] ^ r_b[0];
  assign w_ha1_c = r_a[0] & r_b[0];
  assign w_s     = w_ha1_s ^ r_carry;
  assign w_ha2_c = w_ha1_s & r_carry;
  assign w_co    = w_ha1_c | w_ha2_c;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and datapath control; abort wins over start and over stepping.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_clear     = 1'b1;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = S_FIN;
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_clear     = bus.abort;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/result datapath.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_clear) begin
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_step) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) r_cout <= w_co;
    end
  end

  // Status flags registered from the next state so they track r_state exactly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_FIN);
    end
  end

  assign bus.ready = r_ready;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.sum   = r_sum;
  assign bus.cout  = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8): stimulus pushes expected
// {cout,sum} = a+b+cin on accept; a negedge monitor predicts phase timing
// from the accept cycle and pops/compares on every done.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W:0] m_q[$];
  int         m_acc  = -1;
  logic [W:0] m_hold = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor + reference model: phase is derived from cycles since accept.
  initial begin
    int         d;
    logic       e_run, e_fin, e_idle;
    logic [W:0] exp_r;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_q.delete();
        m_acc  = -1;
        m_hold = '0;
      end
      if (m_acc >= 0 && (cyc - m_acc) >= int'(W) + 2) m_acc = -1;
      d      = (m_acc >= 0) ? (cyc - m_acc) : 0;
      e_run  = (d >= 1) && (d <= int'(W));
      e_fin  = (d == int'(W) + 1);
      e_idle = !e_run && !e_fin;
      chk("ready", 64'(bus.ready), 64'(e_idle));
      chk("busy",  64'(bus.busy),  64'(e_run));
      chk("done",  64'(bus.done),  64'(e_fin));
      if (e_fin) begin
        if (m_q.size() == 0) begin
          chk("result_missing", 64'(m_q.size()), 64'd1);
        end else begin
          exp_r  = m_q.pop_front();
          chk("result", 64'({bus.cout, bus.sum}), 64'(exp_r));
          m_hold = exp_r;
        end
      end else if (e_idle) begin
        chk("held_result", 64'({bus.cout, bus.sum}), 64'(m_hold));
      end
      if (rst_n) begin
        if (e_idle && bus.start && !bus.abort) begin
          m_q.push_back({1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin));
          m_acc  = cyc;
          m_hold = '0;
        end else if (!e_idle && bus.abort) begin
          if (e_run && m_q.size() != 0) void'(m_q.pop_back());
          m_acc  = -1;
          m_hold = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 40) begin
      tick();
      n++;
    end
    chk("ready_wait", 64'(bus.ready), 64'd1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    wait_ready();
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] s, input logic c);
    wait_ready();
    chk(name, 64'({bus.cout, bus.sum}), 64'({c, s}));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (3) tick();
    chk("reset_sum", 64'({bus.cout, bus.sum}), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic, full ripple, all-ones with carry-in, then clean zero add.
    issue(8'h5A, 8'h3C, 1'b0);
    expect_result("add_5a_3c", 8'h96, 1'b0);
    issue(8'hFF, 8'h01, 1'b0);
    expect_result("add_ff_01", 8'h00, 1'b1);
    issue(8'hFF, 8'hFF, 1'b1);
    expect_result("add_ff_ff_c", 8'hFF, 1'b1);
    issue(8'h00, 8'h00, 1'b0);
    expect_result("add_zero", 8'h00, 1'b0);

    // Start held high with operands changing every cycle.
    bus.start = 1'b1;
    repeat (45) begin
      bus.a   = W'($urandom);
      bus.b   = W'($urandom);
      bus.cin = 1'($urandom);
      tick();
    end
    bus.start = 1'b0;
    wait_ready();

    // Reset in the middle of a run, then a fresh add.
    issue(8'h77, 8'h99, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sum", 64'({bus.cout, bus.sum}), 64'd0);
    chk("rst_mid_ready", 64'(bus.ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'h12, 8'h34, 1'b1);
    expect_result("add_after_rst", 8'h47, 1'b0);

    // Abort mid-run, then abort+start together in idle.
    issue(8'hC3, 8'h5F, 1'b0);
    repeat (2) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_ready", 64'(bus.ready), 64'd1);
    chk("abort_sum", 64'({bus.cout, bus.sum}), 64'd0);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abort_start_ready", 64'(bus.ready), 64'd1);

    // Random vectors with occasional aborts.
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(31) == 0) begin
        repeat ($urandom_range(W)) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
      end
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      repeat ($urandom_range(2)) tick();
    end

    repeat (W + 4) tick();
    chk("queue_drained", 64'(m_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
